// File: rtl/neighbor_mc_sync_fifo_pkg.sv
// Shared constants and helpers for the multi-channel neighbor FIFO.
// Optional overflow flag: define NBR_FIFO_OVF_ERR_EN to enable ovf_err.
package nbr_fifo_pkg;

    localparam int NBR_NUM_CH = 4;
    localparam int NBR_DATA_W = 64;
    localparam int NBR_DEPTH  = 8;

    // Payload width expected by the Neighbor_info2Neighbor_FIFO consumer
    localparam int NBR_INFO_W = 64;

    // Index width that never collapses to zero bits (a single channel still needs 1 bit)
    function automatic int nbr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/neighbor_mc_sync_fifo_if.sv
// Bus bundle for neighbor_mc_sync_fifo: per-channel write ports, shared
// read port, occupancy status. ovf_err exists only with NBR_FIFO_OVF_ERR_EN.
interface neighbor_mc_sync_fifo_if
    import nbr_fifo_pkg::*;
#(
    parameter int NUM_CH = NBR_NUM_CH,
    parameter int DATA_W = NBR_DATA_W,
    parameter int DEPTH  = NBR_DEPTH
);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int CHW = nbr_w(NUM_CH);

    logic                           flush;
    logic [NUM_CH-1:0]              wr_valid;
    logic [NUM_CH-1:0][DATA_W-1:0]  wr_data;
    logic [NUM_CH-1:0]              wr_ready;
    logic                           rd_valid;
    logic                           rd_ready;
    logic [DATA_W-1:0]              rd_data;
    logic [CHW-1:0]                 rd_ch;
    logic [NUM_CH-1:0][CW-1:0]      count;
    logic [NUM_CH-1:0]              empty;
    logic [NUM_CH-1:0]              almost_full;
`ifdef NBR_FIFO_OVF_ERR_EN
    logic [NUM_CH-1:0]              ovf_err;

    modport slave (
        input  flush, wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data, rd_ch, count, empty, almost_full, ovf_err
    );
    modport master (
        output flush, wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data, rd_ch, count, empty, almost_full, ovf_err
    );
`else
    modport slave (
        input  flush, wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data, rd_ch, count, empty, almost_full
    );
    modport master (
        output flush, wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data, rd_ch, count, empty, almost_full
    );
`endif

endinterface

// File: rtl/neighbor_mc_sync_fifo_arb.sv
// Combinational rotate-priority arbiter: first requester after 'last', wrapping.
module nbr_rr_arbiter
    import nbr_fifo_pkg::*;
#(
    parameter int NUM_CH = NBR_NUM_CH,
    localparam int CHW   = nbr_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CHW-1:0]    last,
    output logic              gnt_valid,
    output logic [CHW-1:0]    gnt_idx
);

    int idx;

    // Walk from the farthest candidate to the nearest so the nearest requester wins
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = (int'(last) + i) % NUM_CH;
            if (req[idx[CHW-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx[CHW-1:0];
            end
        end
    end

endmodule

// File: rtl/neighbor_mc_sync_fifo.sv
// NUM_CH independent circular FIFOs drained through one registered,
// round-robin arbitrated read port. Build option NBR_FIFO_OVF_ERR_EN adds
// sticky per-channel overflow flags.
module neighbor_mc_sync_fifo
    import nbr_fifo_pkg::*;
#(
    parameter int NUM_CH    = NBR_NUM_CH,
    parameter int DATA_W    = NBR_DATA_W,
    parameter int DEPTH     = NBR_DEPTH,
    parameter int AF_THRESH = DEPTH - 2
) (
    input  logic                      wclk,
    input  logic                      rst_n,
    neighbor_mc_sync_fifo_if.slave    fifo_if
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int CHW = nbr_w(NUM_CH);
    localparam logic [CHW-1:0] RR_INIT = CHW'(NUM_CH - 1);

    logic [DATA_W-1:0]          mem_q [NUM_CH][DEPTH];
    logic [NUM_CH-1:0][CW-1:0]  wr_ptr, rd_ptr, cnt;
    logic [NUM_CH-1:0]          full, empty, wr_en, pop;

    logic                       rd_valid_q;
    logic [DATA_W-1:0]          rd_data_q;
    logic [CHW-1:0]             rd_ch_q, rr_last_q;
    logic                       load, gnt_valid;
    logic [CHW-1:0]             gnt_idx;

    // Output slot can take a new word when empty or being consumed this cycle
    assign load = ~rd_valid_q | fifo_if.rd_ready;

    nbr_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req       (~empty),
        .last      (rr_last_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

        // Full/empty come from registered pointers only, so a same-cycle pop
        // never frees room for a write and a fresh write is never popped at once
        assign full[c]  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        assign empty[c] = (wr_ptr_q == rd_ptr_q);
        assign wr_en[c] = fifo_if.wr_valid[c] & ~full[c] & ~fifo_if.flush;
        assign pop[c]   = load & gnt_valid & (gnt_idx == CHW'(c)) & ~fifo_if.flush;
        assign cnt[c]   = wr_ptr_q - rd_ptr_q;

        assign wr_ptr_d = fifo_if.flush ? '0 : wr_ptr_q + CW'(wr_en[c]);
        assign rd_ptr_d = fifo_if.flush ? '0 : rd_ptr_q + CW'(pop[c]);

        assign wr_ptr[c] = wr_ptr_q;
        assign rd_ptr[c] = rd_ptr_q;

        // Per-channel pointer registers (wrap bit in the MSB)
        always_ff @(posedge wclk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
            end
        end
    end

    // Payload storage; contents are meaningless while pointers say empty
    always_ff @(posedge wclk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_en[c]) mem_q[c][wr_ptr[c][AW-1:0]] <= fifo_if.wr_data[c];
        end
    end

    // Registered read port with round-robin pointer; flush keeps the last payload
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_ch_q    <= '0;
            rr_last_q  <= RR_INIT;
        end else if (fifo_if.flush) begin
            rd_valid_q <= 1'b0;
            rr_last_q  <= RR_INIT;
        end else if (load) begin
            if (gnt_valid) begin
                rd_valid_q <= 1'b1;
                rd_data_q  <= mem_q[gnt_idx][rd_ptr[gnt_idx][AW-1:0]];
                rd_ch_q    <= gnt_idx;
                rr_last_q  <= gnt_idx;
            end else begin
                rd_valid_q <= 1'b0;
            end
        end
    end

`ifdef NBR_FIFO_OVF_ERR_EN
    logic [NUM_CH-1:0] ovf_err_q;

    // Sticky record of any write attempt into a full channel
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n)             ovf_err_q <= '0;
        else if (fifo_if.flush) ovf_err_q <= '0;
        else                    ovf_err_q <= ovf_err_q | (fifo_if.wr_valid & full);
    end

    assign fifo_if.ovf_err = ovf_err_q;
`endif

    assign fifo_if.wr_ready = ~full;
    assign fifo_if.rd_valid = rd_valid_q;
    assign fifo_if.rd_data  = rd_data_q;
    assign fifo_if.rd_ch    = rd_ch_q;
    assign fifo_if.count    = cnt;
    assign fifo_if.empty    = empty;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_af
        assign fifo_if.almost_full[c] = (cnt[c] >= CW'(AF_THRESH));
    end

endmodule

// File: tb/tb_neighbor_mc_sync_fifo.sv
// Directed bench for neighbor_mc_sync_fifo (NUM_CH=4, DATA_W=64, DEPTH=8).
// Checks overflow flags too when built with NBR_FIFO_OVF_ERR_EN.
module tb_neighbor_mc_sync_fifo;

    logic wclk;
    logic rst_n;
    int   checks;
    int   fails;

    neighbor_mc_sync_fifo_if #(.NUM_CH(4), .DATA_W(64), .DEPTH(8)) bus();

    neighbor_mc_sync_fifo #(.NUM_CH(4), .DATA_W(64), .DEPTH(8), .AF_THRESH(6)) dut (
        .wclk    (wclk),
        .rst_n   (rst_n),
        .fifo_if (bus)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge wclk);
        #1;
    endtask

    // Consumer-side monitor: collects accepted words and checks hold stability
    logic [63:0] rx_data[$];
    int          rx_ch[$];
    bit          stab_en;
    bit          hold_pend;
    logic [63:0] hold_data;

    always @(negedge wclk) begin
        if (rst_n) begin
            if (stab_en && hold_pend) begin
                chk("hold_valid", 64'(bus.rd_valid), 64'd1);
                chk("hold_data", bus.rd_data, hold_data);
            end
            hold_pend = bus.rd_valid && !bus.rd_ready;
            hold_data = bus.rd_data;
            if (bus.rd_valid && bus.rd_ready) begin
                rx_data.push_back(bus.rd_data);
                rx_ch.push_back(int'(bus.rd_ch));
            end
        end
    end

    task automatic do_flush();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
    endtask

    initial begin
        int exp_cnt[10] = '{1, 1, 2, 3, 4, 5, 6, 7, 8, 8};
        int sent;
        checks    = 0;
        fails     = 0;
        stab_en   = 1'b0;
        hold_pend = 1'b0;
        hold_data = '0;
        rst_n        = 1'b0;
        bus.flush    = 1'b0;
        bus.wr_valid = '0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        #12;

        // Reset state
        chk("rst_empty", 64'(bus.empty), 64'hF);
        chk("rst_wr_ready", 64'(bus.wr_ready), 64'hF);
        chk("rst_af", 64'(bus.almost_full), 64'h0);
        chk("rst_rd_valid", 64'(bus.rd_valid), 64'h0);
        chk("rst_rd_data", bus.rd_data, 64'h0);
        chk("rst_rd_ch", 64'(bus.rd_ch), 64'h0);
        chk("rst_count", 64'(bus.count), 64'h0);
`ifdef NBR_FIFO_OVF_ERR_EN
        chk("rst_ovf", 64'(bus.ovf_err), 64'h0);
`endif
        @(posedge wclk);
        #1 rst_n = 1'b1;
        step();

        // Single write, two-cycle latency
        bus.wr_valid   = 4'b0100;
        bus.wr_data[2] = 64'hA5;
        bus.rd_ready   = 1'b1;
        step();
        bus.wr_valid = '0;
        chk("t1_cnt_a", 64'(bus.count[2]), 64'd1);
        chk("t1_vld_a", 64'(bus.rd_valid), 64'd0);
        chk("t1_empty_a", 64'(bus.empty[2]), 64'd0);
        step();
        chk("t1_vld_b", 64'(bus.rd_valid), 64'd1);
        chk("t1_data", bus.rd_data, 64'hA5);
        chk("t1_ch", 64'(bus.rd_ch), 64'd2);
        chk("t1_cnt_b", 64'(bus.count[2]), 64'd0);
        chk("t1_empty_b", 64'(bus.empty[2]), 64'd1);
        step();
        chk("t1_vld_c", 64'(bus.rd_valid), 64'd0);

        // Fill channel 0 with the consumer stalled; first word sits in the output register
        bus.rd_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.wr_valid   = 4'b0001;
            bus.wr_data[0] = 64'h100 + 64'(i);
            step();
            chk("t2_cnt", 64'(bus.count[0]), 64'(exp_cnt[i]));
            chk("t2_wr_ready", 64'(bus.wr_ready[0]), (exp_cnt[i] < 8) ? 64'd1 : 64'd0);
            chk("t2_af", 64'(bus.almost_full[0]), (exp_cnt[i] >= 6) ? 64'd1 : 64'd0);
        end
        bus.wr_valid = '0;
`ifdef NBR_FIFO_OVF_ERR_EN
        chk("t2_ovf", 64'(bus.ovf_err), 64'h1);
`endif
        rx_data.delete();
        rx_ch.delete();
        bus.rd_ready = 1'b1;
        step(12);
        chk("t2_rx_n", 64'(rx_data.size()), 64'd9);
        for (int k = 0; k < rx_data.size() && k < 9; k++) begin
            chk("t2_rx_data", rx_data[k], 64'h100 + 64'(k));
            chk("t2_rx_ch", 64'(rx_ch[k]), 64'd0);
        end

        // Fairness across four preloaded channels
        do_flush();
`ifdef NBR_FIFO_OVF_ERR_EN
        chk("t3_ovf_clr", 64'(bus.ovf_err), 64'h0);
`endif
        bus.rd_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.wr_valid = 4'hF;
            for (int c = 0; c < 4; c++) bus.wr_data[c] = 64'hC00 + 64'(c * 16 + k);
            step();
        end
        bus.wr_valid = '0;
        rx_data.delete();
        rx_ch.delete();
        bus.rd_ready = 1'b1;
        step(12);
        chk("t3_rx_n", 64'(rx_data.size()), 64'd12);
        for (int j = 0; j < rx_data.size() && j < 12; j++) begin
            chk("t3_rx_ch", 64'(rx_ch[j]), 64'(j % 4));
            chk("t3_rx_data", rx_data[j], 64'hC00 + 64'((j % 4) * 16 + j / 4));
        end
        step(3);
        chk("t3_rx_extra", 64'(rx_data.size()), 64'd12);

        // Random back-pressure while streaming channel 1
        do_flush();
        rx_data.delete();
        rx_ch.delete();
        stab_en = 1'b1;
        sent    = 0;
        for (int cyc = 0; cyc < 400 && rx_data.size() < 20; cyc++) begin
            bus.rd_ready = 1'($urandom_range(0, 1));
            if (sent < 20 && bus.wr_ready[1]) begin
                bus.wr_valid   = 4'b0010;
                bus.wr_data[1] = 64'hB000 + 64'(sent);
                sent++;
            end else begin
                bus.wr_valid = '0;
            end
            step();
        end
        bus.wr_valid = '0;
        bus.rd_ready = 1'b1;
        step(3);
        stab_en = 1'b0;
        chk("t4_rx_n", 64'(rx_data.size()), 64'd20);
        for (int k = 0; k < rx_data.size() && k < 20; k++) begin
            chk("t4_rx_data", rx_data[k], 64'hB000 + 64'(k));
        end

        // Pointer wrap: concurrent write and read through channel 3
        do_flush();
        rx_data.delete();
        rx_ch.delete();
        bus.rd_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            bus.wr_valid   = 4'b1000;
            bus.wr_data[3] = 64'hD000 + 64'(k);
            step();
            chk("t5_cnt", 64'(bus.count[3]), 64'd1);
        end
        bus.wr_valid = '0;
        step(3);
        chk("t5_cnt_end", 64'(bus.count[3]), 64'd0);
        chk("t5_rx_n", 64'(rx_data.size()), 64'd24);
        for (int k = 0; k < rx_data.size() && k < 24; k++) begin
            chk("t5_rx_data", rx_data[k], 64'hD000 + 64'(k));
            chk("t5_rx_ch", 64'(rx_ch[k]), 64'd3);
        end

        // Flush against a concurrent write and pop
        do_flush();
        bus.rd_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.wr_valid   = 4'b0001;
            bus.wr_data[0] = 64'hF00 + 64'(k);
            step();
        end
        chk("t6_pre_cnt", 64'(bus.count[0]), 64'd5);
        chk("t6_pre_vld", 64'(bus.rd_valid), 64'd1);
        chk("t6_pre_data", bus.rd_data, 64'hF00);
        bus.flush      = 1'b1;
        bus.wr_valid   = 4'b0001;
        bus.wr_data[0] = 64'hDEAD;
        bus.rd_ready   = 1'b1;
        step();
        bus.flush    = 1'b0;
        bus.wr_valid = '0;
        chk("t6_count", 64'(bus.count), 64'h0);
        chk("t6_vld", 64'(bus.rd_valid), 64'd0);
        chk("t6_wr_ready", 64'(bus.wr_ready), 64'hF);
        chk("t6_empty", 64'(bus.empty), 64'hF);
        chk("t6_af", 64'(bus.almost_full), 64'h0);
        chk("t6_data_hold", bus.rd_data, 64'hF00);
        step(2);
        chk("t6_no_store_vld", 64'(bus.rd_valid), 64'd0);
        chk("t6_no_store_cnt", 64'(bus.count[0]), 64'd0);

        // Asynchronous reset mid-operation
        bus.rd_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.wr_valid   = 4'b0100;
            bus.wr_data[2] = 64'hE0 + 64'(k);
            step();
        end
        bus.wr_valid = '0;
        chk("t7_pre_cnt", 64'(bus.count[2]), 64'd1);
        chk("t7_pre_vld", 64'(bus.rd_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_cnt", 64'(bus.count[2]), 64'd0);
        chk("t7_vld", 64'(bus.rd_valid), 64'd0);
        chk("t7_empty", 64'(bus.empty), 64'hF);
        chk("t7_data", bus.rd_data, 64'h0);
        step();
        rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
